multi_shift_unit: RTL and testbench

MULTI_SHIFT_UNIT -- requirements
Module: multi_shift_unit

---
 rtl/multi_shift_unit.sv | 140 ++++++++++++++
 tb/tb_multi_shift_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multi_shift_unit.sv
// Multi-cycle shift/rotate unit: parallel load, then AMT one-bit steps in a
// latched mode, with a carry-out of the last bit shifted out and a done pulse.
module multi_shift_unit #(
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 3
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic [W-1:0]  InA,
  input  logic          PEN,
  input  logic          START,
  input  logic [2:0]    MODE,
  input  logic [SW-1:0] AMT,
  input  logic          InR,
  input  logic          InL,
  output logic [W-1:0]  Out,
  output logic          COUT,
  output logic          BUSY,
  output logic          DONE,
  output logic          ZF
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  out_q, out_d;
  logic          cout_q, cout_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [2:0]    mode_q, mode_d;

  logic [W-1:0]  step_out;
  logic          step_cout;

  // One 1-bit step of the latched mode applied to the current contents.
  always_comb begin
    step_out  = out_q;
    step_cout = cout_q;
    case (mode_q)
      3'b001: begin
        step_out  = {out_q[W-2:0], InR};
        step_cout = out_q[W-1];
      end
      3'b010: begin
        step_out  = {InL, out_q[W-1:1]};
        step_cout = out_q[0];
      end
      3'b011: begin
        step_out  = {out_q[W-1], out_q[W-1:1]};
        step_cout = out_q[0];
      end
      3'b100: begin
        step_out  = {out_q[W-2:0], out_q[W-1]};
        step_cout = out_q[W-1];
      end
      3'b101: begin
        step_out  = {out_q[0], out_q[W-1:1]};
        step_cout = out_q[0];
      end
      3'b110: begin
        step_out  = {out_q[W-2:0], 1'b0};
        step_cout = out_q[W-1];
      end
      3'b111: begin
        step_out  = {1'b0, out_q[W-1:1]};
        step_cout = out_q[0];
      end
      default: begin
        step_out  = out_q;
        step_cout = cout_q;
      end
    endcase
  end

  // Next-state and datapath update; load wins over start in IDLE.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (PEN) begin
          out_d  = InA;
          cout_d = 1'b0;
        end else if (START) begin
          mode_d = MODE;
          if (AMT == '0) begin
            cout_d  = 1'b0;
            state_d = FIN;
          end else begin
            cnt_d   = AMT;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        out_d  = step_out;
        cout_d = step_cout;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= IDLE;
      out_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign Out  = out_q;
  assign COUT = cout_q;
  assign BUSY = (state_q == SHIFT);
  assign DONE = (state_q == FIN);
  assign ZF   = (out_q == '0);

endmodule

// File: tb/tb_multi_shift_unit.sv
// Self-checking bench for multi_shift_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_multi_shift_unit;

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 3;

  logic          CLK = 1'b0;
  logic          RES;
  logic [W-1:0]  InA;
  logic          PEN;
  logic          START;
  logic [2:0]    MODE;
  logic [SW-1:0] AMT;
  logic          InR;
  logic          InL;
  logic [W-1:0]  Out;
  logic          COUT;
  logic          BUSY;
  logic          DONE;
  logic          ZF;

  int checks = 0;
  int errors = 0;

  int m_out  = 0;
  int m_cout = 0;

  multi_shift_unit #(.W(W), .SW(SW)) dut (
    .CLK(CLK), .RES(RES), .InA(InA), .PEN(PEN), .START(START),
    .MODE(MODE), .AMT(AMT), .InR(InR), .InL(InL),
    .Out(Out), .COUT(COUT), .BUSY(BUSY), .DONE(DONE), .ZF(ZF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: one step as plain integer arithmetic on an 8-bit value.
  task automatic mstep(input int md, input int inr, input int inl);
    int v;
    v = m_out;
    case (md)
      1: begin m_cout = v / 128; m_out = (v * 2 + inr) % 256; end
      2: begin m_cout = v % 2;   m_out = v / 2 + inl * 128; end
      3: begin m_cout = v % 2;   m_out = v / 2 + (v / 128) * 128; end
      4: begin m_cout = v / 128; m_out = (v * 2) % 256 + v / 128; end
      5: begin m_cout = v % 2;   m_out = v / 2 + (v % 2) * 128; end
      6: begin m_cout = v / 128; m_out = (v * 2) % 256; end
      7: begin m_cout = v % 2;   m_out = v / 2; end
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_out"},  32'(Out),  32'(m_out));
    chk({tag, "_cout"}, 32'(COUT), 32'(m_cout));
    chk({tag, "_zf"},   32'(ZF),   32'(m_out == 0));
  endtask

  task automatic load(input int val);
    PEN = 1'b1;
    InA = W'(val);
    tick();
    PEN = 1'b0;
    m_out  = val % 256;
    m_cout = 0;
    check_regs("load");
    chk("load_busy", 32'(BUSY), 0);
  endtask

  // Full operation; disturb drives PEN/START while busy, abort>0 resets at that step.
  task automatic do_op(input int md, input int amt, input bit disturb, input int abort);
    START = 1'b1;
    MODE  = 3'(md);
    AMT   = SW'(amt);
    tick();
    START = 1'b0;
    MODE  = 3'($urandom);
    AMT   = SW'($urandom);
    if (amt == 0) m_cout = 0;
    for (int i = 1; i <= amt; i++) begin
      chk("op_busy", 32'(BUSY), 1);
      chk("op_done_low", 32'(DONE), 0);
      InR = 1'($urandom);
      InL = 1'($urandom);
      if (disturb) begin
        PEN   = 1'($urandom);
        START = 1'($urandom);
        InA   = W'($urandom);
      end
      if (i == abort) begin
        RES = 1'b1;
        tick();
        RES = 1'b0;
        PEN = 1'b0;
        START = 1'b0;
        m_out = 0;
        m_cout = 0;
        check_regs("abort");
        chk("abort_busy", 32'(BUSY), 0);
        chk("abort_done", 32'(DONE), 0);
        tick();
        chk("abort_no_done", 32'(DONE), 0);
        chk("abort_idle", 32'(BUSY), 0);
        return;
      end
      mstep(md, int'(InR), int'(InL));
      tick();
      check_regs("step");
    end
    chk("fin_done", 32'(DONE), 1);
    chk("fin_busy", 32'(BUSY), 0);
    check_regs("fin");
    PEN   = disturb;
    START = disturb;
    InA   = W'($urandom);
    tick();
    PEN   = 1'b0;
    START = 1'b0;
    chk("idle_done", 32'(DONE), 0);
    chk("idle_busy", 32'(BUSY), 0);
    check_regs("idle");
  endtask

  initial begin
    RES = 1'b1; InA = '0; PEN = 1'b0; START = 1'b0;
    MODE = 3'b000; AMT = '0; InR = 1'b0; InL = 1'b0;
    tick();
    tick();
    chk("rst_out", 32'(Out), 0);
    chk("rst_cout", 32'(COUT), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_zf", 32'(ZF), 1);
    RES = 1'b0;

    load(8'hA5);
    chk("a5_const", 32'(Out), 32'h A5);

    load(8'h81);
    do_op(4, 3, 1'b0, 0);
    chk("rol_const", 32'(Out), 32'h0C);
    chk("rol_cout", 32'(COUT), 0);

    load(8'h80);
    do_op(3, 7, 1'b0, 0);
    chk("sra_const", 32'(Out), 32'hFF);
    chk("sra_cout", 32'(COUT), 0);

    load(8'h80);
    do_op(7, 7, 1'b0, 0);
    chk("srl0_const", 32'(Out), 32'h01);
    chk("srl0_zf", 32'(ZF), 0);

    load(8'h5A);
    do_op(1, 0, 1'b0, 0);
    chk("amt0_out", 32'(Out), 32'h5A);

    load(8'hC3);
    do_op(1, 5, 1'b1, 0);
    load(8'hC3);
    do_op(1, 5, 1'b0, 3);
    do_op(5, 2, 1'b0, 0);

    PEN = 1'b1; START = 1'b1; InA = 8'h3C; MODE = 3'b001; AMT = 3'd4;
    tick();
    PEN = 1'b0; START = 1'b0;
    m_out = 8'h3C; m_cout = 0;
    check_regs("pen_start");
    chk("pen_start_busy", 32'(BUSY), 0);
    chk("pen_start_done", 32'(DONE), 0);
    tick();
    chk("pen_start_busy2", 32'(BUSY), 0);
    chk("pen_start_done2", 32'(DONE), 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) load(int'($urandom_range(0, 255)));
      do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
